// File: rtl/poly_mm_pkg.sv
// poly_mm_pkg: shared secret-width derivation, ternary encoding and FSM state type.
// Build option: TERNARY_SK_EN selects 2-bit ternary secret coefficients.
package poly_mm_pkg;
`ifdef TERNARY_SK_EN
    localparam int SK_W = 2;
`else
    localparam int SK_W = 1;
`endif
    localparam logic [1:0] SK_POS   = 2'b01;
    localparam logic [1:0] SK_NEG   = 2'b11;
    localparam logic [1:0] SK_ZERO  = 2'b00;
    localparam logic [1:0] SK_ZERO2 = 2'b10;
    typedef enum logic {EMPTY, LOADED} state_t;
endpackage

// File: rtl/poly_lane_mac.sv
// poly_lane_mac: combinational sum over i+j==K of A_i*s_j, mod 2^COEFF_W.
// Ports: a_data_i packed A lanes, s_data_i packed secret lanes, lane_o result lane.
// Build option: TERNARY_SK_EN (secret lanes are +1/-1/0 instead of 1/0).
module poly_lane_mac
    import poly_mm_pkg::*;
#(
    parameter int COEFF_W = 18,
    parameter int A_LANES = 2,
    parameter int S_LANES = 2,
    parameter int K       = 0
) (
    input  logic [A_LANES*COEFF_W-1:0] a_data_i,
    input  logic [S_LANES*SK_W-1:0]    s_data_i,
    output logic [COEFF_W-1:0]         lane_o
);
    function automatic logic [COEFF_W-1:0] term(input logic [COEFF_W-1:0] a, input logic [SK_W-1:0] s);
`ifdef TERNARY_SK_EN
        return (s == SK_POS) ? a : (s == SK_NEG) ? -a : '0;
`else
        return s[0] ? a : '0;
`endif
    endfunction

    always_comb begin
        lane_o = '0;
        for (int i = 0; i < A_LANES; i++)
            for (int j = 0; j < S_LANES; j++)
                if (i + j == K)
                    lane_o = lane_o + term(a_data_i[i*COEFF_W +: COEFF_W], s_data_i[j*SK_W +: SK_W]);
    end
endmodule

// File: rtl/poly_partial_mm.sv
// poly_partial_mm: holds one A word and streams secret words against it, producing partial products.
// Ports: A stream (a_valid/a_ready/a_data/a_idx/tag_in), s stream (s_valid/s_ready/s_data/s_idx),
//        product stream (out_valid/out_ready/out_data/out_idx/tag_out), sticky seq_err.
// Build option: TERNARY_SK_EN selects ternary secret coefficients.
module poly_partial_mm
    import poly_mm_pkg::*;
#(
    parameter int COEFF_W = 18,
    parameter int A_LANES = 2,
    parameter int S_LANES = 2,
    parameter int DEPTH   = 784,
    parameter int IDX_W   = 10,
    parameter int TAG_W   = 10
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   a_valid,
    output logic                                   a_ready,
    input  logic [A_LANES*COEFF_W-1:0]             a_data,
    input  logic [IDX_W-1:0]                       a_idx,
    input  logic [TAG_W-1:0]                       tag_in,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [S_LANES*SK_W-1:0]                s_data,
    input  logic [IDX_W-1:0]                       s_idx,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [(A_LANES+S_LANES-1)*COEFF_W-1:0] out_data,
    output logic [IDX_W:0]                         out_idx,
    output logic [TAG_W-1:0]                       tag_out,
    output logic                                   seq_err
);
    localparam int OUT_LANES = A_LANES + S_LANES - 1;

    state_t                         state_q;
    logic                           out_valid_q, seq_err_q;
    logic [IDX_W-1:0]               exp_idx_q, a_idx_q;
    logic [A_LANES*COEFF_W-1:0]     a_data_q;
    logic [TAG_W-1:0]               tag_q, tag_out_q;
    logic [OUT_LANES*COEFF_W-1:0]   out_data_q, prod;
    logic [IDX_W:0]                 out_idx_q;
    logic                           a_hs, s_hs, last;

    // Ready lines are gated by reset so nothing is offered while rst_in is high.
    assign a_ready = (state_q == EMPTY) && !rst_in;
    assign s_ready = (state_q == LOADED) && (!out_valid_q || out_ready) && !rst_in;
    assign a_hs    = a_valid && a_ready;
    assign s_hs    = s_valid && s_ready;
    assign last    = s_idx == IDX_W'(DEPTH - S_LANES);

    for (genvar k = 0; k < OUT_LANES; k++) begin : g_lane
        poly_lane_mac #(.COEFF_W(COEFF_W), .A_LANES(A_LANES), .S_LANES(S_LANES), .K(k)) u_mac (
            .a_data_i(a_data_q),
            .s_data_i(s_data),
            .lane_o  (prod[k*COEFF_W +: COEFF_W])
        );
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            exp_idx_q   <= '0;
        end else begin
            if (a_hs) begin
                state_q   <= LOADED;
                exp_idx_q <= '0;
            end
            if (s_hs) begin
                if (s_idx != exp_idx_q) seq_err_q <= 1'b1;
                // Next index follows the index actually received, so one bad word flags once.
                exp_idx_q <= s_idx + IDX_W'(S_LANES);
                if (last) state_q <= EMPTY;
            end
            out_valid_q <= s_hs || (out_valid_q && !out_ready);
        end
    end

    // Product registers are loaded only on s handshakes, so they stay put through an A reload.
    always_ff @(posedge clk_in) begin
        if (a_hs) begin
            a_data_q <= a_data;
            a_idx_q  <= a_idx;
            tag_q    <= tag_in;
        end
        if (s_hs) begin
            out_data_q <= prod;
            out_idx_q  <= {1'b0, a_idx_q} + {1'b0, s_idx};
            tag_out_q  <= tag_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign tag_out   = tag_out_q;
    assign seq_err   = seq_err_q;
endmodule

// File: tb/tb_poly_partial_mm.sv
// tb_poly_partial_mm: directed self-checking bench for poly_partial_mm at default parameters.
module tb_poly_partial_mm;
    import poly_mm_pkg::*;

    logic              clk_in = 1'b0, rst_in = 1'b1;
    logic              a_valid = 1'b0, a_ready;
    logic [35:0]       a_data = '0;
    logic [9:0]        a_idx = '0, tag_in = '0;
    logic              s_valid = 1'b0, s_ready;
    logic [2*SK_W-1:0] s_data = '0;
    logic [9:0]        s_idx = '0;
    logic              out_valid, out_ready = 1'b1;
    logic [53:0]       out_data;
    logic [10:0]       out_idx;
    logic [9:0]        tag_out;
    logic              seq_err;
    int                total = 0, bad = 0;

    poly_partial_mm dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_idx(a_idx), .tag_in(tag_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_idx(s_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .tag_out(tag_out), .seq_err(seq_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Map a bit per lane to the secret encoding: 1 -> +1, 0 -> 0.
    function automatic logic [2*SK_W-1:0] sb(input logic [1:0] b);
        logic [2*SK_W-1:0] r;
        r = '0;
        for (int j = 0; j < 2; j++) r[j*SK_W +: SK_W] = b[j] ? SK_W'(1) : '0;
        return r;
    endfunction

    initial begin
        step();
        step();
        chk("rst_a_ready", a_ready, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_seq_err", seq_err, 0);
        rst_in = 1'b0;
        step();
        chk("post_rst_a_ready", a_ready, 1);

        a_valid = 1'b1; a_data = {18'd5, 18'd3}; a_idx = 10'd4; tag_in = 10'd9;
        step();
        a_valid = 1'b0;
        chk("loaded_a_ready", a_ready, 0);
        chk("loaded_s_ready", s_ready, 1);
        s_valid = 1'b1; s_data = sb(2'b11); s_idx = 10'd0;
        step();
        s_valid = 1'b0;
        chk("basic_valid", out_valid, 1);
        chk("basic_data", out_data, {18'd5, 18'd8, 18'd3});
        chk("basic_idx", out_idx, 11'd4);
        chk("basic_tag", tag_out, 10'd9);
        step();
        chk("drain_valid", out_valid, 0);

        out_ready = 1'b0; s_valid = 1'b1; s_data = sb(2'b01); s_idx = 10'd2;
        step();
        s_data = sb(2'b10); s_idx = 10'd4;
        for (int c = 0; c < 3; c++) begin
            chk("bp_s_ready", s_ready, 0);
            chk("bp_data", out_data, {18'd0, 18'd5, 18'd3});
            chk("bp_idx", out_idx, 11'd6);
            step();
        end
        out_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_data", out_data, {18'd5, 18'd3, 18'd0});
        chk("bp_next_idx", out_idx, 11'd8);
        step();

        s_valid = 1'b1; s_data = sb(2'b00);
        for (int i = 6; i <= 780; i += 2) begin
            s_idx = 10'(i);
            step();
        end
        chk("stream_seq_err", seq_err, 0);
        s_data = sb(2'b01); s_idx = 10'd782;
        step();
        s_valid = 1'b0; out_ready = 1'b0;
        chk("eos_a_ready", a_ready, 1);
        chk("eos_valid", out_valid, 1);
        chk("eos_idx", out_idx, 11'd786);
        chk("eos_data", out_data, {18'd0, 18'd5, 18'd3});
        a_valid = 1'b1; a_data = {18'd1, 18'h3FFFF}; a_idx = 10'd0; tag_in = 10'd3;
        step();
        a_valid = 1'b0;
        chk("reload_a_ready", a_ready, 0);
        chk("reload_s_ready", s_ready, 0);
        chk("reload_held_data", out_data, {18'd0, 18'd5, 18'd3});
        chk("reload_held_tag", tag_out, 10'd9);

        out_ready = 1'b1; s_valid = 1'b1; s_data = sb(2'b11); s_idx = 10'd0;
        step();
        chk("wrap_data", out_data, {18'd1, 18'd0, 18'h3FFFF});
        chk("wrap_tag", tag_out, 10'd3);
        chk("wrap_seq_err", seq_err, 0);

        s_idx = 10'd4;
        step();
        chk("seq_err_set", seq_err, 1);
        chk("seq_idx", out_idx, 11'd4);
        chk("seq_valid", out_valid, 1);
        s_valid = 1'b0;
        step();
        chk("seq_err_sticky", seq_err, 1);

        out_ready = 1'b0; s_valid = 1'b1; s_idx = 10'd6;
        step();
        s_valid = 1'b0;
        chk("pend_valid", out_valid, 1);
        rst_in = 1'b1;
        step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_seq_err", seq_err, 0);
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        rst_in = 1'b0; out_ready = 1'b1;
        step();
        chk("rel_a_ready", a_ready, 1);
        chk("rel_valid", out_valid, 0);
        chk("rel_seq_err", seq_err, 0);

`ifdef TERNARY_SK_EN
        a_valid = 1'b1; a_data = {18'd0, 18'd7}; a_idx = 10'd0; tag_in = 10'd1;
        step();
        a_valid = 1'b0; s_valid = 1'b1; s_data = {SK_NEG, SK_POS}; s_idx = 10'd0;
        step();
        s_valid = 1'b0;
        chk("tern_data", out_data, {18'd0, 18'h3FFF9, 18'd7});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/poly_partial_mm.md
POLY_PARTIAL_MM -- requirements
Module: poly_partial_mm

Interface
REQ-001 Parameter COEFF_W, default 18, coefficient width in bits; all arithmetic is mod 2^COEFF_W.
REQ-002 Parameter A_LANES, default 2, public-key coefficients packed per A word.
REQ-003 Parameter S_LANES, default 2, secret coefficients packed per s word.
REQ-004 Parameter DEPTH, default 784, polynomial length in coefficients; DEPTH is a multiple of S_LANES.
REQ-005 Parameter IDX_W, default 10, index width.
REQ-006 Parameter TAG_W, default 10, pass-through tag width.
REQ-007 The clock is clk_in, input, 1 bit, and is the single clock; all logic is on its rising edge.
REQ-008 The reset is rst_in, input, 1 bit, synchronous and active-high.
REQ-009 Port a_valid, input, 1: A word offered.
REQ-010 Port a_ready, output, 1: A word accepted when a_valid is also high.
REQ-011 Port a_data, input, A_LANES*COEFF_W: lane i is a_data[i*COEFF_W +: COEFF_W].
REQ-012 Port a_idx, input, IDX_W: index of A lane 0.
REQ-013 Port tag_in, input, TAG_W: tag captured with A.
REQ-014 Port s_valid, input, 1: s word offered.
REQ-015 Port s_ready, output, 1: s word accepted when s_valid is also high.
REQ-016 Port s_data, input, S_LANES*SK_W: SK_W=1, or 2 under TERNARY_SK_EN.
REQ-017 Port s_idx, input, IDX_W: index of s lane 0.
REQ-018 Port out_valid, output, 1: product word valid.
REQ-019 Port out_ready, input, 1: consumer accepts the product word.
REQ-020 Port out_data, output, (A_LANES+S_LANES-1)*COEFF_W: product lanes.
REQ-021 Port out_idx, output, IDX_W+1: a_idx+s_idx, no truncation.
REQ-022 Port tag_out, output, TAG_W: tag of the held A word.
REQ-023 Port seq_err, output, 1: sticky s-index sequencing error.

Function
REQ-024 The FSM SHALL have exactly two states: EMPTY (no A held) and LOADED (A held).
REQ-025 In EMPTY, a_ready=1 and s_ready=0; an A handshake captures a_data, a_idx and tag_in, and moves the FSM to LOADED.
REQ-026 In LOADED, a_ready=0 and s_ready=(!out_valid || out_ready).
REQ-027 On an s handshake, the product SHALL be registered into out_data, out_idx and tag_out, with out_valid=1 on the next cycle (latency 1 cycle).
REQ-028 With out_ready held high, one s word SHALL be accepted per cycle.
REQ-029 Output lane k SHALL equal the sum over i+j=k of A_i*s_j, mod 2^COEFF_W, with two's-complement wrap.
REQ-030 out_valid SHALL clear after an output handshake if no new s word is accepted in the same cycle.
REQ-031 While out_valid=1 and out_ready=0, out_data, out_idx and tag_out SHALL remain stable.
REQ-032 An s handshake with s_idx == DEPTH-S_LANES is the last s word; the FSM SHALL return to EMPTY on the next cycle, so a_ready=1 on that cycle.
REQ-033 The held A word and its product registers SHALL remain valid until out_valid is accepted, independent of the FSM returning to EMPTY.
REQ-034 The first s word for each A word SHALL have s_idx=0, and each following s word SHALL have s_idx equal to the previous s_idx plus S_LANES; any other s_idx SHALL set seq_err=1.
REQ-035 A sequencing error SHALL NOT stall or alter the datapath, and seq_err SHALL stay set until reset.

Reset
REQ-036 While rst_in=1: the FSM SHALL be in EMPTY, out_valid=0, seq_err=0, a_ready=0 and s_ready=0.
REQ-037 On the first cycle after reset is released, a_ready SHALL be 1.
REQ-038 A reset mid-stream SHALL discard the held A word and any pending product.
REQ-039 Data registers need no reset value.

Configuration
REQ-040 When macro TERNARY_SK_EN is defined, SK_W=2 and the coefficient encoding is 2'b01=+1, 2'b11=-1, 2'b00=0 and 2'b10=0.
REQ-041 When TERNARY_SK_EN is defined, a -1 coefficient SHALL subtract A_i mod 2^COEFF_W.
REQ-042 When TERNARY_SK_EN is not defined, SK_W=1 and each secret bit selects +A_i or 0.

Structure
REQ-043 A shared package poly_mm_pkg SHALL hold the SK_W derivation, the ternary encoding localparams and the typedef of the FSM state enum.
REQ-044 The block SHALL contain one sub-module, poly_lane_mac, which computes one output lane combinationally and is instantiated A_LANES+S_LANES-1 times.

Verification (defaults: COEFF_W=18, A_LANES=2, S_LANES=2)
REQ-045 Basic product: A lanes {lane1=5, lane0=3}, a_idx=4, tag_in=9, s=2'b11, s_idx=0 -> out lanes {5,8,3}, out_idx=4, tag_out=9, one cycle after the s handshake.
REQ-046 Wrap: A {lane1=1, lane0=18'h3FFFF}, s=2'b11 -> lane1=0, lane0=18'h3FFFF, lane2=1.
REQ-047 Backpressure: hold out_ready=0 for 3 cycles with s_valid=1 -> outputs stable, s_ready=0; release out_ready -> exactly one output transfer, then the next s word is accepted.
REQ-048 End of stream: s_idx=782 accepted -> a_ready=1 on the next cycle; a new A word is accepted while the last product is still held under out_ready=0.
REQ-049 Ternary (TERNARY_SK_EN defined): A {lane1=0, lane0=7}, s lane0=+1 and lane1=-1 -> lanes {0, 18'h3FFF9, 7}.
REQ-050 Sequencing error and reset: s_idx sequence 0 then 4 -> seq_err=1 and remains set; assert rst_in mid-stream -> seq_err=0, out_valid=0, a_ready=1 on the first cycle after release.
